// File: rtl/csi_param_pkg.sv
// Shared types, constants and header/footer checksum functions for the CSI-2 packet builder.
package csi_param_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAY, CRC} csi_pkt_state_t;

    localparam logic [5:0]  C_CSI_SHORT_DT_MAX = 6'h0F;
    localparam logic [15:0] C_CSI_CRC_INIT     = 16'hFFFF;

    // Each mask selects the header bits covered by one Hamming parity bit P0..P5.
    function automatic logic [7:0] csi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return {2'b00, p};
    endfunction

    // Reflected form of x^16+x^12+x^5+1, processing the byte LSB first.
    function automatic logic [15:0] csi_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi_crc16.sv
// Byte-wide CRC-16 accumulator for the long-packet payload.
module csi_crc16
    import csi_param_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;

    always_ff @(posedge clk) begin
        if (!rstn || init) begin
            crc_reg <= C_CSI_CRC_INIT;
        end else if (en) begin
            crc_reg <= csi_crc16_byte(crc_reg, data);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/csi_pkt_builder.sv
// CSI-2 transmit packet builder: header + payload + CRC footer serialised through one output register.
module csi_pkt_builder
    import csi_param_pkg::*;
#(
    parameter int P_WC_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_vc,
    input  logic [5:0]            cmd_dt,
    input  logic [P_WC_WIDTH-1:0] cmd_wc,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop
);

    localparam logic [P_WC_WIDTH-1:0] WC_ONE = 1;

    csi_pkt_state_t          state_reg, state_next;
    logic [P_WC_WIDTH+7:0]   hdr_reg;
    logic [7:0]              ecc_reg;
    logic                    short_reg;
    logic [P_WC_WIDTH-1:0]   cnt_reg;
    logic [P_WC_WIDTH-1:0]   wc_reg;
    logic [15:0]             crc;

    logic       load;
    logic       adv;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_sop;
    logic       byte_eop;
    logic       byte_last;
    logic       cmd_fire;
    logic       in_fire;

    assign wc_reg   = hdr_reg[P_WC_WIDTH+7:8];
    assign load     = !out_valid || out_ready;
    assign adv      = load && byte_valid;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (cmd_fire) state_next = HDR;
            HDR: begin
                if (adv && byte_last) begin
                    if (short_reg)            state_next = IDLE;
                    else if (wc_reg == '0)    state_next = CRC;
                    else                      state_next = PAY;
                end
            end
            PAY: if (adv && byte_last) state_next = CRC;
            CRC: if (adv && byte_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Describes the byte the output register would take this cycle; it only loads when load is high.
    always_comb begin
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_sop   = 1'b0;
        byte_eop   = 1'b0;
        byte_last  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                cmd_ready  = rstn && load;
                byte_valid = cmd_valid;
                byte_data  = {cmd_vc, cmd_dt};
                byte_sop   = 1'b1;
            end
            HDR: begin
                byte_valid = 1'b1;
                case (cnt_reg[1:0])
                    2'd0:    byte_data = hdr_reg[15:8];
                    2'd1:    byte_data = hdr_reg[23:16];
                    default: begin
                        byte_data = ecc_reg;
                        byte_eop  = short_reg;
                        byte_last = 1'b1;
                    end
                endcase
            end
            PAY: begin
                in_ready   = rstn && load;
                byte_valid = in_valid;
                byte_data  = in_data;
                byte_last  = (cnt_reg == wc_reg - WC_ONE);
            end
            CRC: begin
                byte_valid = 1'b1;
                byte_data  = cnt_reg[0] ? crc[15:8] : crc[7:0];
                byte_eop   = cnt_reg[0];
                byte_last  = cnt_reg[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hdr_reg   <= '0;
            ecc_reg   <= 8'h00;
            short_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            if (cmd_fire) begin
                hdr_reg   <= {cmd_wc, cmd_vc, cmd_dt};
                ecc_reg   <= csi_ecc({cmd_wc, cmd_vc, cmd_dt});
                short_reg <= (cmd_dt <= C_CSI_SHORT_DT_MAX);
            end
            // The counter restarts at every phase boundary and indexes bytes within the phase.
            if (adv) begin
                if (state_reg == IDLE || byte_last) cnt_reg <= '0;
                else                                cnt_reg <= cnt_reg + WC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load) begin
            out_valid <= byte_valid;
            if (byte_valid) begin
                out_data <= byte_data;
                out_sop  <= byte_sop;
                out_eop  <= byte_eop;
            end
        end
    end

    csi_crc16 u_crc (
        .clk  (clk),
        .rstn (rstn),
        .init (cmd_fire),
        .en   (in_fire),
        .data (in_data),
        .crc  (crc)
    );

endmodule

// File: tb/tb_csi_pkt_builder.sv
// Directed bench for csi_pkt_builder with an expected-byte scoreboard on the output stream.
module tb_csi_pkt_builder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_vc;
    logic [5:0]  cmd_dt;
    logic [15:0] cmd_wc;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic stall_mode = 1'b0;

    logic [7:0] pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                             8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                             8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    csi_pkt_builder #(.P_WC_WIDTH(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_vc    (cmd_vc),
        .cmd_dt    (cmd_dt),
        .cmd_wc    (cmd_wc),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic e);
        exp_q.push_back('{d: d, s: s, e: e});
    endtask

    task automatic push_long_pay(input int n);
        for (int i = 0; i < n; i++) push(pay[i], 1'b0, 1'b0);
    endtask

    task automatic send_cmd(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        int guard;
        cmd_vc = vc; cmd_dt = dt; cmd_wc = wc; cmd_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk); #1;
                break;
            end
            guard++;
            if (guard > 1000) begin
                chk("cmd_accept_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_payload(input int n, input logic rnd);
        int guard;
        for (int i = 0; i < n; i++) begin
            in_data  = pay[i];
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            guard = 0;
            forever begin
                @(negedge clk);
                if (in_valid && in_ready) begin
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
                if (rnd) in_valid = 1'($urandom_range(0, 1));
                guard++;
                if (guard > 1000) break;
            end
            if (guard > 1000) begin
                chk("payload_timeout", 32'(i), 32'(n));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Downstream model: always ready, or randomly stalling half the time.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each handshake and checks stability while stalled.
    initial begin
        logic       held_v;
        logic [9:0] held;
        exp_t       e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("stall_stable", {21'd0, out_valid, out_data, out_sop, out_eop},
                        {21'd0, 1'b1, held});
                end
                if (out_valid === 1'b1 && out_ready) begin
                    chk("unexpected_byte", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_byte", {22'd0, out_data, out_sop, out_eop}, {22'd0, e});
                    end
                end
                held_v = (out_valid === 1'b1) && !out_ready;
                held   = {out_data, out_sop, out_eop};
            end
        end
    end

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_vc = 2'd0; cmd_dt = 6'd0; cmd_wc = 16'd0;
        in_data = 8'h00; in_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_sop",   32'(out_sop),   32'd0);
        chk("rst_out_eop",   32'(out_eop),   32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Short packet, all zero, with cmd_ready returning right after the ECC byte is loaded.
        push(8'h00, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
        send_cmd(2'd0, 6'h00, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("ready_after_short", 32'(cmd_ready), 32'd1);
        wait_drain("short0_drain");

        // Short packet whose ECC depends only on D0.
        push(8'h01, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h07, 1'b0, 1'b1);
        send_cmd(2'd0, 6'h01, 16'h0000);
        wait_drain("short1_drain");

        // Long packet, 24 payload bytes, continuous flow.
        push(8'h2A, 1'b1, 1'b0); push(8'h18, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h13, 1'b0, 1'b0);
        push_long_pay(24);
        push(8'hF0, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
        chk("long_len", 32'(exp_q.size()), 32'd30);
        send_cmd(2'd0, 6'h2A, 16'd24);
        send_payload(24, 1'b0);
        wait_drain("long_drain");

        // Same packet with random input starvation and output backpressure.
        push(8'h2A, 1'b1, 1'b0); push(8'h18, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h13, 1'b0, 1'b0);
        push_long_pay(24);
        push(8'hF0, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
        stall_mode = 1'b1;
        send_cmd(2'd0, 6'h2A, 16'd24);
        send_payload(24, 1'b1);
        wait_drain("stall_drain");
        stall_mode = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Long packet with no payload: footer is the untouched init value.
        push(8'h2A, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h10, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0); push(8'hFF, 1'b0, 1'b1);
        send_cmd(2'd0, 6'h2A, 16'd0);
        wait_drain("wc0_drain");

        // Reset in the middle of the payload.
        push(8'h2A, 1'b1, 1'b0); push(8'h18, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h13, 1'b0, 1'b0);
        push_long_pay(10);
        send_cmd(2'd0, 6'h2A, 16'd24);
        send_payload(10, 1'b0);
        rstn = 1'b0;
        chk("pre_reset_backlog", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;

        push(8'h01, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h07, 1'b0, 1'b1);
        send_cmd(2'd0, 6'h01, 16'h0000);
        wait_drain("post_abort_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
